led_pattern_gen: RTL

- Multi-channel LED driver for the board top level. It is the parametrised successor of the single free-running blink LED.
- Each channel runs one of four modes: off, fixed brightness (PWM), blink, or breathe (triangular brightness ramp).
- A shared prescaler provides the pattern timebase. Per-channel settings are loaded through a simple one-cycle write strobe.

---
 rtl/led_pattern_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / fixed PWM / blink / breathe
// patterns driven from a shared prescaled tick and a free-running PWM counter.
module led_pattern_gen #(
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 16000,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 10,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [1:0]             cfg_mode,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [PWM_BITS-1:0]    cfg_duty,
  output logic                   tick,
  output logic [CHANNELS-1:0]    led
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]        PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]        PS_ONE   = PS_W'(1);
  localparam logic [PWM_BITS-1:0]    PWM_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0]    PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0]    PWM_FULL = {PWM_BITS{1'b1}};
  localparam logic [PERIOD_BITS-1:0] PER_ZERO = {PERIOD_BITS{1'b0}};
  localparam logic [PERIOD_BITS-1:0] PER_ONE  = PERIOD_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PS_W-1:0]        presc_q, presc_d;
  logic                   tick_q, tick_d;
  logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0]    led_q, led_d;

  mode_e                  mode_q   [CHANNELS];
  mode_e                  mode_d   [CHANNELS];
  logic [PERIOD_BITS-1:0] period_q [CHANNELS];
  logic [PERIOD_BITS-1:0] period_d [CHANNELS];
  logic [PERIOD_BITS-1:0] step_q   [CHANNELS];
  logic [PERIOD_BITS-1:0] step_d   [CHANNELS];
  logic [PWM_BITS-1:0]    duty_q   [CHANNELS];
  logic [PWM_BITS-1:0]    duty_d   [CHANNELS];
  logic [PWM_BITS-1:0]    bright_q [CHANNELS];
  logic [PWM_BITS-1:0]    bright_d [CHANNELS];
  logic                   phase_q  [CHANNELS];
  logic                   phase_d  [CHANNELS];
  dir_e                   dir_q    [CHANNELS];
  dir_e                   dir_d    [CHANNELS];
  logic                   step_evt_s [CHANNELS];
  logic                   cfg_valid_s;

  // A full-scale level must light the LED 100%, which a plain compare never reaches.
  function automatic logic pwm_on(input logic [PWM_BITS-1:0] level,
                                  input logic [PWM_BITS-1:0] cnt);
    return (level == PWM_FULL) || (cnt < level);
  endfunction

  function automatic logic [PERIOD_BITS-1:0] period_last(input logic [PERIOD_BITS-1:0] period);
    logic [PERIOD_BITS-1:0] last;
    if (period == PER_ZERO) begin
      last = PER_ZERO;
    end else begin
      last = period - PER_ONE;
    end
    return last;
  endfunction

  // Next-state logic: timebase, PWM counter, per-channel step/phase/breathe FSM, config writes.
  always_comb begin
    cfg_valid_s = cfg_we && (32'(cfg_ch) < 32'(CHANNELS));

    if (presc_q == PS_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PS_ONE;
      tick_d  = 1'b0;
    end

    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    led_d     = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]     = mode_q[i];
      period_d[i]   = period_q[i];
      duty_d[i]     = duty_q[i];
      step_d[i]     = step_q[i];
      phase_d[i]    = phase_q[i];
      bright_d[i]   = bright_q[i];
      dir_d[i]      = dir_q[i];
      step_evt_s[i] = 1'b0;

      if (((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BREATHE)) && tick_q) begin
        if (step_q[i] == period_last(period_q[i])) begin
          step_d[i]     = PER_ZERO;
          step_evt_s[i] = 1'b1;
        end else begin
          step_d[i] = step_q[i] + PER_ONE;
        end
      end else begin
        step_d[i] = step_q[i];
      end

      case (mode_q[i])
        MODE_OFF: begin
          led_d[i] = 1'b0;
        end
        MODE_ON: begin
          led_d[i] = pwm_on(duty_q[i], pwm_cnt_q);
        end
        MODE_BLINK: begin
          led_d[i] = phase_q[i] & pwm_on(duty_q[i], pwm_cnt_q);
          if (step_evt_s[i]) begin
            phase_d[i] = ~phase_q[i];
          end else begin
            phase_d[i] = phase_q[i];
          end
        end
        MODE_BREATHE: begin
          led_d[i] = pwm_on(bright_q[i], pwm_cnt_q);
          if (!step_evt_s[i]) begin
            bright_d[i] = bright_q[i];
          end else if (duty_q[i] == PWM_ZERO) begin
            bright_d[i] = PWM_ZERO;
          end else begin
            case (dir_q[i])
              DIR_UP: begin
                if (bright_q[i] == duty_q[i]) begin
                  dir_d[i]    = DIR_DOWN;
                  bright_d[i] = bright_q[i] - PWM_ONE;
                end else begin
                  bright_d[i] = bright_q[i] + PWM_ONE;
                end
              end
              DIR_DOWN: begin
                if (bright_q[i] == PWM_ZERO) begin
                  dir_d[i]    = DIR_UP;
                  bright_d[i] = bright_q[i] + PWM_ONE;
                end else begin
                  bright_d[i] = bright_q[i] - PWM_ONE;
                end
              end
              default: begin
                dir_d[i]    = DIR_UP;
                bright_d[i] = PWM_ZERO;
              end
            endcase
          end
        end
        default: begin
          led_d[i] = 1'b0;
        end
      endcase

      // A write restarts the channel and wins over a step event on the same edge.
      if (cfg_valid_s && (cfg_ch == CH_W'(i))) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        step_d[i]   = PER_ZERO;
        phase_d[i]  = 1'b0;
        bright_d[i] = PWM_ZERO;
        dir_d[i]    = DIR_UP;
      end else begin
        mode_d[i] = mode_d[i];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        step_q[i]   <= '0;
        phase_q[i]  <= 1'b0;
        bright_q[i] <= '0;
        dir_q[i]    <= DIR_UP;
      end
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        step_q[i]   <= step_d[i];
        phase_q[i]  <= phase_d[i];
        bright_q[i] <= bright_d[i];
        dir_q[i]    <= dir_d[i];
      end
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule
